// File: rtl/rgb_raw_pkg.sv
`default_nettype none
// ============================================================
// Package : rgb_raw_pkg
// Pixel width, Bayer order / colour types, phase decode, bar table.
// Rev     : 1.0
// ============================================================
package rgb_raw_pkg;

  localparam int PIX_W = 10;

  typedef enum logic [1:0] {
    ORDER_GRBG = 2'd0,
    ORDER_RGGB = 2'd1,
    ORDER_BGGR = 2'd2,
    ORDER_GBRG = 2'd3
  } bayer_order_e;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } colour_e;

  // Bar colours packed as {R,G,B} full-scale enables.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic colour_e phase_colour(input bayer_order_e order, input logic y, input logic x);
    logic    g_on_diag;
    logic    r_on_row0;
    colour_e c;
    // GRBG/GBRG keep green where y==x; the other two put it where y!=x.
    g_on_diag = (order == ORDER_GRBG) || (order == ORDER_GBRG);
    r_on_row0 = (order == ORDER_GRBG) || (order == ORDER_RGGB);
    if ((y == x) == g_on_diag)
      c = GREEN;
    else if ((y == 1'b0) == r_on_row0)
      c = RED;
    else
      c = BLUE;
    return c;
  endfunction

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_phase_counter.sv
`default_nettype none
// ============================================================
// Module : bayer_phase_counter
// Frame FSM, column/row counters and end-of-frame pulse.
// Rev    : 1.0
// ============================================================
module bayer_phase_counter
  import rgb_raw_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_W    = $clog2(H_ACTIVE),
  parameter int ROW_W    = $clog2(V_ACTIVE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fval,
  input  logic             i_dval,
  output logic             o_accept,
  output logic [COL_W-1:0] o_col,
  output logic             o_row_lsb,
  output logic             o_eof
);

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_ACTIVE     = 2'd1,
    S_DONE       = 2'd2
  } frame_state_e;

  frame_state_e     r_state;
  logic             r_fval_d;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_eof;

  logic w_rise;
  logic w_accept;
  logic w_col_last;
  logic w_row_last;
  logic w_frame_last;

  assign w_rise       = i_fval & ~r_fval_d;
  assign w_accept     = i_fval & i_dval & (r_state == S_ACTIVE);
  assign w_col_last   = (r_col == COL_W'(H_ACTIVE - 1));
  assign w_row_last   = (r_row == ROW_W'(V_ACTIVE - 1));
  assign w_frame_last = w_accept & w_col_last & w_row_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_WAIT_FRAME;
      r_fval_d <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_eof    <= 1'b0;
    end else begin
      r_fval_d <= i_fval;
      r_eof    <= 1'b0;
      case (r_state)
        S_WAIT_FRAME: if (w_rise) r_state <= S_ACTIVE;
        S_ACTIVE: begin
          if (w_frame_last)
            r_state <= S_DONE;
          else if (!i_fval)
            r_state <= S_WAIT_FRAME;
        end
        // Pulse lands one cycle after DONE so it lines up with the last pixel on oRAW.
        S_DONE: begin
          r_eof   <= 1'b1;
          r_state <= S_WAIT_FRAME;
        end
        default: r_state <= S_WAIT_FRAME;
      endcase

      if (!i_fval || w_rise || w_frame_last) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          if (!w_row_last) r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_accept  = w_accept;
  assign o_col     = r_col;
  assign o_row_lsb = r_row[0];
  assign o_eof     = r_eof;

endmodule
`default_nettype wire

// File: rtl/rgb_to_raw_bayer.sv
`default_nettype none
// ============================================================
// Module : rgb_to_raw_bayer
// Re-mosaics RGB into a Bayer RAW stream; RGB2RAW_TESTBAR_EN adds colour bars on iTEST.
// Rev    : 1.0
// ============================================================
module rgb_to_raw_bayer
  import rgb_raw_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BAYER_ORDER = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [PIX_W-1:0] iR,
  input  logic [PIX_W-1:0] iG,
  input  logic [PIX_W-1:0] iB,
  input  logic             iTEST,
  output logic [PIX_W-1:0] oRAW,
  output logic             oDVAL,
  output logic             oX,
  output logic             oY,
  output logic             oEOF
);

  localparam int           COL_W   = $clog2(H_ACTIVE);
  localparam int           ROW_W   = $clog2(V_ACTIVE);
  localparam bayer_order_e c_order = bayer_order_e'(BAYER_ORDER[1:0]);

  logic             w_accept;
  logic [COL_W-1:0] w_col;
  logic             w_row_lsb;
  logic             w_eof;
  logic [PIX_W-1:0] w_src_r;
  logic [PIX_W-1:0] w_src_g;
  logic [PIX_W-1:0] w_src_b;
  logic [PIX_W-1:0] w_sel;

  logic             r_s1_vld;
  logic [PIX_W-1:0] r_s1_r;
  logic [PIX_W-1:0] r_s1_g;
  logic [PIX_W-1:0] r_s1_b;
  logic             r_s1_x;
  logic             r_s1_y;
  logic             r_s2_vld;
  logic [PIX_W-1:0] r_s2_raw;
  logic             r_s2_x;
  logic             r_s2_y;

  bayer_phase_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_counter (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .i_fval    (iFVAL),
    .i_dval    (iDVAL),
    .o_accept  (w_accept),
    .o_col     (w_col),
    .o_row_lsb (w_row_lsb),
    .o_eof     (w_eof)
  );

`ifdef RGB2RAW_TESTBAR_EN
  logic [2:0] w_bar_idx;
  logic [2:0] w_bar_rgb;

  assign w_bar_idx = 3'((32'(w_col) * 32'd8) / 32'(H_ACTIVE));
  assign w_bar_rgb = bar_rgb(w_bar_idx);
  assign w_src_r   = iTEST ? {PIX_W{w_bar_rgb[2]}} : iR;
  assign w_src_g   = iTEST ? {PIX_W{w_bar_rgb[1]}} : iG;
  assign w_src_b   = iTEST ? {PIX_W{w_bar_rgb[0]}} : iB;
`else
  logic w_unused_sig;

  assign w_unused_sig = iTEST ^ (^w_col);
  assign w_src_r      = iR;
  assign w_src_g      = iG;
  assign w_src_b      = iB;
`endif

  always_comb begin
    w_sel = r_s1_b;
    case (phase_colour(c_order, r_s1_y, r_s1_x))
      RED:     w_sel = r_s1_r;
      GREEN:   w_sel = r_s1_g;
      default: w_sel = r_s1_b;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_s1_vld <= 1'b0;
      r_s1_r   <= '0;
      r_s1_g   <= '0;
      r_s1_b   <= '0;
      r_s1_x   <= 1'b0;
      r_s1_y   <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_raw <= '0;
      r_s2_x   <= 1'b0;
      r_s2_y   <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_r <= w_src_r;
        r_s1_g <= w_src_g;
        r_s1_b <= w_src_b;
        r_s1_x <= w_col[0];
        r_s1_y <= w_row_lsb;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_raw <= w_sel;
        r_s2_x   <= r_s1_x;
        r_s2_y   <= r_s1_y;
      end
    end
  end

  assign oRAW  = r_s2_raw;
  assign oDVAL = r_s2_vld;
  assign oX    = r_s2_x;
  assign oY    = r_s2_y;
  assign oEOF  = w_eof;

endmodule
`default_nettype wire
